// File: rtl/of_pkg.sv
// of_pkg: shared state encoding, edge-flag positions and helpers
// for the Horn-Schunck iteration scheduler.
package of_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_SWAP,
    S_DONE
  } state_t;

  localparam int EDGE_TOP   = 3;
  localparam int EDGE_BOT   = 2;
  localparam int EDGE_LEFT  = 1;
  localparam int EDGE_RIGHT = 0;

  function automatic int unsigned n_pix(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

  // A zero sweep count still runs one sweep.
  function automatic int unsigned eff_iters(
    input int unsigned c
  );
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/of_iter_sched_if.sv
// of_iter_sched_if: control, gradient-load, pixel-issue and
// result-writeback signals of the iteration scheduler.
interface of_iter_sched_if #(
  parameter int ADDR_W = 12,
  parameter int ITER_W = 8
);

  logic              start;
  logic [ITER_W-1:0] cfg_iters;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_idx;

  logic              grad_val;
  logic              grad_rdy;
  logic              gmem_we;
  logic [ADDR_W-1:0] gmem_waddr;

  logic              pix_val;
  logic              pix_rdy;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] pix_row;
  logic [ADDR_W-1:0] pix_col;
  logic [3:0]        pix_edge;
  logic              pix_last;

  logic              res_val;
  logic              res_rdy;
  logic              uv_we;
  logic [ADDR_W-1:0] uv_waddr;
  logic              uv_wbank;

  modport master (
    input  start, cfg_iters,
    input  grad_val, pix_rdy, res_val,
    output busy, done, iter_idx,
    output grad_rdy, gmem_we, gmem_waddr,
    output pix_val, pix_addr, pix_row,
    output pix_col, pix_edge, pix_last,
    output res_rdy, uv_we, uv_waddr, uv_wbank
  );

  modport slave (
    output start, cfg_iters,
    output grad_val, pix_rdy, res_val,
    input  busy, done, iter_idx,
    input  grad_rdy, gmem_we, gmem_waddr,
    input  pix_val, pix_addr, pix_row,
    input  pix_col, pix_edge, pix_last,
    input  res_rdy, uv_we, uv_waddr, uv_wbank
  );

endinterface

// File: rtl/of_raster_cnt.sv
// of_raster_cnt: raster-order row/col/addr counter with
// end-of-frame and border flags.
module of_raster_cnt
  import of_pkg::*;
#(
  parameter int W  = 64,
  parameter int H  = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic [3:0]    edges
);

  localparam logic [AW-1:0] COL_MAX  = AW'(W - 1);
  localparam logic [AW-1:0] ROW_MAX  = AW'(H - 1);
  localparam logic [AW-1:0] ADDR_MAX =
    AW'(n_pix(W, H) - 1);

  assign last = (addr == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
      addr <= last ? '0 : addr + AW'(1);
    end
  end

  always_comb begin
    edges             = '0;
    edges[EDGE_TOP]   = (row == '0);
    edges[EDGE_BOT]   = (row == ROW_MAX);
    edges[EDGE_LEFT]  = (col == '0);
    edges[EDGE_RIGHT] = (col == COL_MAX);
  end

endmodule

// File: rtl/of_iter_sched.sv
// of_iter_sched: loads one gradient frame, then runs the requested
// number of HS sweeps into a ping-pong flow buffer.
module of_iter_sched
  import of_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int ADDR_W     = 12,
  parameter int ITER_W     = 8,
  parameter int MAX_OUTST  = 4
) (
  input logic             clk,
  input logic             reset,
  of_iter_sched_if.master bus
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTST);

  state_t state, state_nx;

  logic [ITER_W-1:0] iters;
  logic [ITER_W-1:0] iter_idx;
  logic [OW-1:0]     outst;
  logic              bank;
  logic              cnt_clr;
  logic              last_iter;

  logic grad_fire, pix_fire, res_fire, sweep_end;

  logic [ADDR_W-1:0] iss_row, iss_col, iss_addr;
  logic              iss_last;
  logic [3:0]        iss_edge;

  logic [ADDR_W-1:0] wr_row, wr_col, wr_addr;
  logic              wr_last;
  logic [3:0]        wr_edge;
  logic              wr_unused;

  // Write side serves gradient loads, then flow writeback.
  of_raster_cnt #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT),
    .AW(ADDR_W)
  ) u_wr (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clr),
    .inc  (grad_fire | res_fire),
    .row  (wr_row),
    .col  (wr_col),
    .addr (wr_addr),
    .last (wr_last),
    .edges(wr_edge)
  );

  of_raster_cnt #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT),
    .AW(ADDR_W)
  ) u_iss (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clr),
    .inc  (pix_fire),
    .row  (iss_row),
    .col  (iss_col),
    .addr (iss_addr),
    .last (iss_last),
    .edges(iss_edge)
  );

  assign wr_unused = ^{wr_row, wr_col, wr_edge};

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.iter_idx = iter_idx;

  assign bus.grad_rdy   = (state == S_LOAD);
  assign grad_fire      = bus.grad_val & bus.grad_rdy;
  assign bus.gmem_we    = grad_fire;
  assign bus.gmem_waddr = wr_addr;

  assign bus.pix_val  = (state == S_ISSUE) && (outst < OUT_MAX);
  assign pix_fire     = bus.pix_val & bus.pix_rdy;
  assign bus.pix_addr = iss_addr;
  assign bus.pix_row  = iss_row;
  assign bus.pix_col  = iss_col;
  assign bus.pix_edge = iss_edge;
  assign bus.pix_last = iss_last;

  // Never accept a result with nothing in flight.
  assign bus.res_rdy  = ((state == S_ISSUE) || (state == S_DRAIN))
                        && (outst != '0);
  assign res_fire     = bus.res_val & bus.res_rdy;
  assign bus.uv_we    = res_fire;
  assign bus.uv_waddr = wr_addr;
  assign bus.uv_wbank = bank;

  assign sweep_end = res_fire & wr_last;
  assign last_iter = ((iter_idx + ITER_W'(1)) == iters);

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = S_LOAD;
          cnt_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (grad_fire && wr_last) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (sweep_end)
          state_nx = S_SWAP;
        else if (pix_fire && iss_last)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (sweep_end) state_nx = S_SWAP;
      end
      S_SWAP: begin
        cnt_clr  = 1'b1;
        state_nx = last_iter ? S_DONE : S_ISSUE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      iters    <= '0;
      iter_idx <= '0;
      bank     <= 1'b0;
      outst    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.start) begin
        iters    <= ITER_W'(eff_iters(32'(bus.cfg_iters)));
        iter_idx <= '0;
        bank     <= 1'b0;
      end
      if (state == S_SWAP) begin
        bank <= ~bank;
        if (!last_iter) iter_idx <= iter_idx + ITER_W'(1);
      end
      if (pix_fire && !res_fire)
        outst <= outst + OW'(1);
      else if (res_fire && !pix_fire)
        outst <= outst - OW'(1);
    end
  end

endmodule
